button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Per-channel input conditioner for the board push-buttons.
- Chain: asynchronous raw pins -> 2-flop synchronizer -> counter-based debouncer -> polarity normalisation -> single-cycle press/release pulse generation.
- btn_clean drives the 4-bit in_port of the buttons PIO slave directly.
- press_pulse/release_pulse are available to local logic, e.g. an edge-capture/IRQ stage.

Parameters:
- WIDTH, 4: number of button channels; all channels are identical and independent.
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a new synchronized level must persist before it is accepted (10 ms at 50 MHz). Legal range is 2 or more.
- ACTIVE_LOW, 1: 1 means a pin at 0 is "pressed"; 0 means a pin at 1 is "pressed".

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_raw  in  WIDTH  raw button pins, asynchronous to clk.
- btn_clean  out  WIDTH  debounced level, active-high (1 = pressed), registered.
- press_pulse  out  WIDTH  one-cycle pulse when a channel's btn_clean goes 0->1, registered.
- release_pulse  out  WIDTH  one-cycle pulse when a channel's btn_clean goes 1->0, registered.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Synchronizer flops load the released pin level (1 if ACTIVE_LOW, else 0).
  - Counters load 0.
  - btn_clean, press_pulse and release_pulse load all-zeros.
  - All state holds until the first clk edge after reset_n deasserts.
- Normalisation: pressed = ACTIVE_LOW ? ~sync2 : sync2, applied after the synchronizer. The stable state is kept active-high and equals btn_clean.
- Counter width: $clog2(DEBOUNCE_CYCLES). One counter per channel.
- Per channel, each clk edge:
  - pressed == btn_clean: counter <= 0.
  - pressed != btn_clean and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - pressed != btn_clean and counter == DEBOUNCE_CYCLES-1: btn_clean toggles and counter <= 0.
- Latency:
  - A clean raw transition sampled by sync1 at edge k reaches sync2 at edge k+1.
  - The mismatch is first counted at edge k+2.
  - btn_clean changes at edge k+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges after first capture.
- Glitch rejection: any return to agreement before the count completes clears the counter and leaves btn_clean unchanged. A bouncing input restarts the count at each agreement.
- Pulses:
  - press_pulse[i] is asserted on the same edge btn_clean[i] goes 0->1, for exactly one cycle.
  - release_pulse[i] likewise for 1->0.
  - Both pulses are never high together on one channel.
  - Pulses are never generated by reset entry or reset exit.
- Channels are independent. Simultaneous transitions on several channels produce simultaneous pulses on those channels in the same cycle.
- Reset mid-count: the counter is discarded and btn_clean returns to 0. A button held through reset is accepted as a fresh press DEBOUNCE_CYCLES+2 edges after reset release, and press_pulse fires at that point.
- No counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1.
- Metastability: only sync1 samples btn_raw. No logic other than sync2 reads sync1.

Test Plan:
(All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.)
1. Reset with btn_raw=4'hF, then release reset -> btn_clean=0, press_pulse=0 and release_pulse=0 on every cycle for 20 cycles.
2. btn_raw[0] 1->0, held low -> btn_clean[0]=1 on the 6th edge after first capture, press_pulse=4'h1 for exactly that one cycle, other bits stay 0. Then raise btn_raw[0] -> btn_clean[0]=0 six edges later, release_pulse=4'h1 for one cycle.
3. btn_raw[1] low for 3 cycles, high 1, low 2, high 1 (bounce), then low steadily -> btn_clean[1] stays 0 during the bounce. It rises only after 4 consecutive counted low cycles; exactly one press_pulse[1] is produced.
4. btn_raw goes 4'hF -> 4'h0 on one cycle -> btn_clean goes 4'h0 -> 4'hF on a single edge, with press_pulse=4'hF for one cycle.
5. Hold btn_raw[2] low; assert reset_n low mid-count (counter=2), then after btn_clean[2]=1 assert reset again. In both cases btn_clean=0 immediately (asynchronous, without a clk edge) and no pulse is produced. After release, btn_clean[2]=1 with press_pulse[2] six edges after the first capture.
6. Toggle btn_raw[3] every 2 cycles for 50 cycles -> btn_clean[3] never changes, no pulses, and the counter never exceeds 3.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronize, debounce, polarity-normalise and edge-pulse push-buttons
module button_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_clean,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE = ACTIVE_LOW ? '1 : '0;

    logic [WIDTH-1:0] sync1, sync2, pressed, done;
    logic [CW-1:0] cnt [WIDTH];

    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

    // A channel is accepted once its disagreement has lasted the whole debounce window
    always_comb begin
        done = '0;
        for (int j = 0; j < WIDTH; j++) done[j] = (pressed[j] != btn_clean[j]) && (cnt[j] == LAST);
    end

    // Two-flop synchronizer; only sync1 ever samples the asynchronous pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Debounce counters, accepted level and one-cycle edge pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_clean     <= '0;
            press_pulse   <= '0;
            release_pulse <= '0;
            for (int j = 0; j < WIDTH; j++) cnt[j] <= '0;
        end else begin
            btn_clean     <= btn_clean ^ done;
            press_pulse   <= done & ~btn_clean;
            release_pulse <= done & btn_clean;
            for (int j = 0; j < WIDTH; j++)
                cnt[j] <= (pressed[j] == btn_clean[j] || done[j]) ? '0 : cnt[j] + 1'b1;
        end
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: random and directed stimulus checked against a window-based reference model
module tb_button_conditioner;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 0;
    logic         reset_n = 0;
    logic [W-1:0] btn_raw = '1;
    logic [W-1:0] btn_clean, press_pulse, release_pulse;

    int checks = 0;
    int failures = 0;

    button_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .btn_clean(btn_clean), .press_pulse(press_pulse), .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples pass a two-deep delay line; a channel's accepted level
    // flips when the last D pressed levels it saw all differ from the accepted level.
    logic [W-1:0] m_clean = '0, m_press = '0, m_rel = '0;
    logic [W-1:0] smp [$];
    logic [W-1:0] hist [$];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp = {};
            smp.push_back('1);
            smp.push_back('1);
            hist = {};
            m_clean <= '0;
            m_press <= '0;
            m_rel   <= '0;
        end else begin
            logic [W-1:0] nc, np, nr;
            bit all_diff;
            nc = m_clean;
            np = '0;
            nr = '0;
            hist.push_back(~smp[smp.size()-2]);
            smp.push_back(btn_raw);
            if (smp.size() > 4) void'(smp.pop_front());
            if (hist.size() > 2*D) void'(hist.pop_front());
            if (hist.size() >= D) begin
                for (int c = 0; c < W; c++) begin
                    all_diff = 1;
                    for (int t = 0; t < D; t++)
                        if (hist[hist.size()-1-t][c] == m_clean[c]) all_diff = 0;
                    if (all_diff) begin
                        nc[c] = ~m_clean[c];
                        np[c] = ~m_clean[c];
                        nr[c] = m_clean[c];
                    end
                end
            end
            m_clean <= nc;
            m_press <= np;
            m_rel   <= nr;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and compare every output against the model away from the edge
    task automatic cyc();
        @(negedge clk);
        chk("model_clean", btn_clean, m_clean);
        chk("model_press", press_pulse, m_press);
        chk("model_release", release_pulse, m_rel);
        chk("pulse_overlap", press_pulse & release_pulse, '0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic async_reset_check(input string name);
        reset_n = 0;
        #1;
        chk({name, "_clean_now"}, btn_clean, '0);
        chk({name, "_press_now"}, press_pulse, '0);
        chk({name, "_release_now"}, release_pulse, '0);
    endtask

    initial begin
        int presses;
        int budget;
        logic [6:0] bounce;
        int hold [W];
        // 1: reset with all pins released, then 20 quiet cycles
        cycles(3);
        reset_n = 1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_clean", btn_clean, '0);
            chk("idle_pulses", press_pulse | release_pulse, '0);
        end
        // 2: single press and release on channel 0, six edges after capture
        btn_raw = 4'hE;
        cycles(5);
        chk("press_edge5_clean", btn_clean, 4'h0);
        cyc();
        chk("press_edge6_clean", btn_clean, 4'h1);
        chk("press_edge6_pulse", press_pulse, 4'h1);
        cyc();
        chk("press_edge7_pulse", press_pulse, 4'h0);
        btn_raw = 4'hF;
        cycles(5);
        chk("release_edge5_clean", btn_clean, 4'h1);
        cyc();
        chk("release_edge6_clean", btn_clean, 4'h0);
        chk("release_edge6_pulse", release_pulse, 4'h1);
        cyc();
        chk("release_edge7_pulse", release_pulse, 4'h0);
        cycles(4);
        // 3: bounce on channel 1 (L L L H L L H) then steady low
        bounce = 7'b1001000;
        presses = 0;
        for (int i = 0; i < 7; i++) begin
            btn_raw[1] = bounce[i];
            cyc();
            if (press_pulse[1]) presses++;
        end
        btn_raw[1] = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (press_pulse[1]) presses++;
        end
        checks++;
        if (presses != 1) begin
            failures++;
            $display("FAIL bounce_press_count actual=%0d expected=1", presses);
        end
        chk("bounce_final_clean", btn_clean, 4'h2);
        btn_raw = 4'hF;
        cycles(8);
        // 4: all channels pressed together
        btn_raw = 4'h0;
        budget = 0;
        while (btn_clean == 4'h0 && budget < 12) begin
            cyc();
            budget++;
        end
        chk("all_press_clean", btn_clean, 4'hF);
        chk("all_press_pulse", press_pulse, 4'hF);
        checks++;
        if (budget != 6) begin
            failures++;
            $display("FAIL all_press_latency actual=%0d expected=6", budget);
        end
        btn_raw = 4'hF;
        cycles(8);
        // 5: reset mid-count and after acceptance while channel 2 is held
        btn_raw = 4'hB;
        cycles(4);
        async_reset_check("mid_count");
        cycles(2);
        reset_n = 1;
        cycles(5);
        chk("rst1_edge5_clean", btn_clean, 4'h0);
        cyc();
        chk("rst1_edge6_clean", btn_clean, 4'h4);
        chk("rst1_edge6_press", press_pulse, 4'h4);
        cycles(3);
        async_reset_check("accepted");
        cycles(3);
        reset_n = 1;
        cycles(5);
        chk("rst2_edge5_clean", btn_clean, 4'h0);
        cyc();
        chk("rst2_edge6_clean", btn_clean, 4'h4);
        chk("rst2_edge6_press", press_pulse, 4'h4);
        btn_raw = 4'hF;
        cycles(8);
        // 6: channel 3 toggling every 2 cycles never settles
        for (int i = 0; i < 50; i++) begin
            if (i % 2 == 0) btn_raw[3] = ~btn_raw[3];
            cyc();
            chk("toggle_clean", btn_clean, 4'h0);
            chk("toggle_pulses", press_pulse | release_pulse, 4'h0);
        end
        btn_raw = 4'hF;
        cycles(8);
        // Random bouncing per channel with occasional resets
        for (int c = 0; c < W; c++) hold[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < W; c++) begin
                if (hold[c] == 0) begin
                    btn_raw[c] = 1'($urandom_range(1));
                    hold[c] = $urandom_range(1, 9);
                end
                hold[c]--;
            end
            if ($urandom_range(199) == 0) begin
                async_reset_check("random");
                cycles($urandom_range(1, 3));
                reset_n = 1;
            end
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
